vector_mac_pipe: RTL and testbench

Pipelined, handshaked successor to the combinational vector MAC. It instantiates one `mac` per lane across `VECTOR` lanes and adds input/output registers, valid/ready flow control, a per-lane enable mask and an accumulate mode for multi-beat dot products. It sits between the vector operand fetch and the writeback stage of the FPU datapath.

---
 rtl/vector_mac_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_vector_mac_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mac_pipe.sv
// Pipelined vector FMA: per-lane mac behind an input register and an output
// register, with valid/ready flow control, lane masking and multi-beat accumulation.
module mac #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  localparam int I_WIDTH = 1 + E_WIDTH + M_WIDTH
) (
  input  logic [I_WIDTH-1:0] i_a,
  input  logic [I_WIDTH-1:0] i_b,
  input  logic [I_WIDTH-1:0] i_c,
  output logic [I_WIDTH-1:0] o_r
);
  localparam int BIAS = (1 << (E_WIDTH - 1)) - 1;
  localparam int PW = 2 * M_WIDTH + 2;
  localparam int G = M_WIDTH + 4;
  localparam int W = PW + G;
  localparam int XW = E_WIDTH + 4;
  localparam logic [E_WIDTH-1:0] EALL = '1;
  localparam logic signed [XW-1:0] EINF = XW'((1 << E_WIDTH) - 1);
  localparam logic signed [XW-1:0] EONE = XW'(1);
  localparam logic signed [XW-1:0] EOFS = XW'(2 * M_WIDTH + G);
  localparam logic signed [XW-1:0] EBIAS = XW'(BIAS);

  logic w_sa, w_sb, w_sc, w_sp;
  logic [E_WIDTH-1:0] w_ea, w_eb, w_ec;
  logic [M_WIDTH-1:0] w_fa, w_fb, w_fc;
  logic [M_WIDTH:0] w_ma, w_mb, w_mc, w_mr;
  logic [PW-1:0] w_pm, w_cm;
  logic signed [XW-1:0] w_xp, w_xc, w_xb, w_er;
  logic w_ia, w_ib, w_ic, w_na, w_nb, w_nc;
  logic w_pinf, w_nan;
  logic [W-1:0] w_big, w_sml, w_sh, w_nrm;
  logic [W:0] w_sum;
  logic w_sbig, w_ssml, w_rs, w_st, w_g, w_st2, w_rnd;
  int w_d, w_lead;

  assign {w_sa, w_ea, w_fa} = i_a;
  assign {w_sb, w_eb, w_fb} = i_b;
  assign {w_sc, w_ec, w_fc} = i_c;

  // Subnormal inputs are flushed to zero.
  assign w_ma = {|w_ea, w_fa & {M_WIDTH{|w_ea}}};
  assign w_mb = {|w_eb, w_fb & {M_WIDTH{|w_eb}}};
  assign w_mc = {|w_ec, w_fc & {M_WIDTH{|w_ec}}};

  assign w_pm = PW'(w_ma) * PW'(w_mb);
  assign w_cm = PW'(w_mc) << M_WIDTH;
  assign w_sp = w_sa ^ w_sb;
  assign w_xp = $signed({4'b0, w_ea}) + $signed({4'b0, w_eb}) - EBIAS;
  assign w_xc = $signed({4'b0, w_ec});

  assign w_ia = (w_ea == EALL) && (w_fa == '0);
  assign w_ib = (w_eb == EALL) && (w_fb == '0);
  assign w_ic = (w_ec == EALL) && (w_fc == '0);
  assign w_na = (w_ea == EALL) && (w_fa != '0);
  assign w_nb = (w_eb == EALL) && (w_fb != '0);
  assign w_nc = (w_ec == EALL) && (w_fc != '0);
  assign w_pinf = w_ia | w_ib;
  assign w_nan = w_na | w_nb | w_nc
               | (w_ia & ~|w_mb) | (w_ib & ~|w_ma)
               | (w_pinf & w_ic & (w_sp ^ w_sc));

  always_comb begin
    w_big = {w_pm, {G{1'b0}}};
    w_sml = {w_cm, {G{1'b0}}};
    w_sbig = w_sp;
    w_ssml = w_sc;
    w_xb = w_xp;
    w_d = 0;
    if (w_pm == '0) begin
      w_big = {w_cm, {G{1'b0}}};
      w_sml = '0;
      w_sbig = w_sc;
      w_xb = w_xc;
    end else if (w_mc == '0) begin
      w_sml = '0;
    end else if (w_xc > w_xp) begin
      w_big = {w_cm, {G{1'b0}}};
      w_sml = {w_pm, {G{1'b0}}};
      w_sbig = w_sc;
      w_ssml = w_sp;
      w_xb = w_xc;
      w_d = int'(w_xc - w_xp);
    end else begin
      w_d = int'(w_xp - w_xc);
    end
    if (w_d >= W) begin
      w_sh = '0;
      w_st = |w_sml;
    end else begin
      w_sh = w_sml >> w_d;
      w_st = |(w_sml & ((W'(1) << w_d) - W'(1)));
    end
    w_sh[0] = w_sh[0] | w_st;
    w_rs = w_sbig;
    if (w_sbig == w_ssml) begin
      w_sum = {1'b0, w_big} + {1'b0, w_sh};
    end else if (w_big >= w_sh) begin
      w_sum = {1'b0, w_big - w_sh};
    end else begin
      w_sum = {1'b0, w_sh - w_big};
      w_rs = w_ssml;
    end
    w_lead = 0;
    for (int i = 0; i <= W; i++) begin
      if (w_sum[i]) w_lead = i;
    end
    // Leading one shifted out of the top; fraction starts at W-1.
    w_nrm = W'(w_sum << (W - w_lead));
    w_g = w_nrm[W-1-M_WIDTH];
    w_st2 = |w_nrm[W-2-M_WIDTH:0];
    w_mr = {1'b0, w_nrm[W-1 -: M_WIDTH]};
    w_rnd = w_g & (w_st2 | w_mr[0]);
    w_mr = w_mr + {{M_WIDTH{1'b0}}, w_rnd};
    w_er = $signed(XW'(w_lead)) + w_xb - EOFS;
    if (w_mr[M_WIDTH]) w_er = w_er + EONE;
    if (w_nan) begin
      o_r = {1'b0, EALL, 1'b1, {(M_WIDTH-1){1'b0}}};
    end else if (w_pinf) begin
      o_r = {w_sp, EALL, {M_WIDTH{1'b0}}};
    end else if (w_ic) begin
      o_r = {w_sc, EALL, {M_WIDTH{1'b0}}};
    end else if (w_sum == '0) begin
      o_r = '0;
    end else if (w_er >= EINF) begin
      o_r = {w_rs, EALL, {M_WIDTH{1'b0}}};
    end else if (w_er < EONE) begin
      o_r = {w_rs, {(I_WIDTH-1){1'b0}}};
    end else begin
      o_r = {w_rs, w_er[E_WIDTH-1:0], w_mr[M_WIDTH-1:0]};
    end
  end
endmodule

module vector_mac_pipe #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int VECTOR = 4,
  parameter int CNT_WIDTH = 16,
  localparam int I_WIDTH = 1 + E_WIDTH + M_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic                 first,
  input  logic                 last,
  input  logic [VECTOR-1:0]    lane_mask,
  input  logic [I_WIDTH-1:0]   a_in [VECTOR],
  input  logic [I_WIDTH-1:0]   b_in [VECTOR],
  input  logic [I_WIDTH-1:0]   c_in [VECTOR],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [I_WIDTH-1:0]   out [VECTOR],
  output logic [CNT_WIDTH-1:0] out_count
);
  logic r_s1_valid, r_mode, r_first, r_last;
  logic [VECTOR-1:0] r_mask;
  logic [I_WIDTH-1:0] r_a [VECTOR];
  logic [I_WIDTH-1:0] r_b [VECTOR];
  logic [I_WIDTH-1:0] r_c [VECTOR];
  logic [I_WIDTH-1:0] r_acc [VECTOR];
  logic [I_WIDTH-1:0] r_out [VECTOR];
  logic r_seq_open, r_out_valid;
  logic [CNT_WIDTH-1:0] r_beat_cnt, r_out_count, w_cnt;
  logic [I_WIDTH-1:0] w_add [VECTOR];
  logic [I_WIDTH-1:0] w_mac [VECTOR];
  logic [I_WIDTH-1:0] w_res [VECTOR];
  logic w_emit, w_retire, w_accept;

  assign w_emit = ~r_mode | r_last;
  assign w_retire = r_s1_valid & (~w_emit | ~r_out_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_retire;
  assign w_accept = in_valid & in_ready;

  for (genvar i = 0; i < VECTOR; i++) begin : g_lane
    assign w_add[i] = (~r_mode | r_first) ? r_c[i] :
                      (r_seq_open ? r_acc[i] : '0);
    mac #(
      .E_WIDTH(E_WIDTH),
      .M_WIDTH(M_WIDTH)
    ) u_mac (
      .i_a(r_a[i]),
      .i_b(r_b[i]),
      .i_c(w_add[i]),
      .o_r(w_mac[i])
    );
    assign w_res[i] = r_mask[i] ? w_mac[i] : w_add[i];
  end

  always_comb begin
    w_cnt = CNT_WIDTH'(1);
    if (r_mode && !r_first && r_seq_open) begin
      w_cnt = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_mode <= 1'b0;
      r_first <= 1'b0;
      r_last <= 1'b0;
      r_mask <= '0;
      for (int i = 0; i < VECTOR; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_c[i] <= '0;
      end
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_mode <= mode;
      r_first <= first;
      r_last <= last;
      r_mask <= lane_mask;
      r_a <= a_in;
      r_b <= b_in;
      r_c <= c_in;
    end else if (w_retire) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_seq_open <= 1'b0;
      r_beat_cnt <= '0;
      for (int i = 0; i < VECTOR; i++) begin
        r_out[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      if (w_retire && w_emit) begin
        r_out_valid <= 1'b1;
        r_out <= w_res;
        r_out_count <= w_cnt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Mode 0 beats pass through without disturbing an open sequence.
      if (w_retire && r_mode) begin
        if (r_last) begin
          r_seq_open <= 1'b0;
          r_beat_cnt <= '0;
          for (int i = 0; i < VECTOR; i++) r_acc[i] <= '0;
        end else begin
          r_seq_open <= 1'b1;
          r_beat_cnt <= w_cnt;
          r_acc <= w_res;
        end
      end
    end
  end

  assign out = r_out;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
endmodule

// File: tb/tb_vector_mac_pipe.sv
// Bench for vector_mac_pipe: integer-valued FP32 operands so every result is
// exact, checked against an integer dot-product model and literal values.
module tb_vector_mac_pipe;
  localparam int V = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, mode, first, last;
  logic out_valid, out_ready;
  logic [V-1:0] lane_mask;
  logic [31:0] a_in [V];
  logic [31:0] b_in [V];
  logic [31:0] c_in [V];
  logic [31:0] out [V];
  logic [15:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;

  int sa [V];
  int sb [V];
  int sc [V];
  bit s_mode, s_first, s_last;
  logic [V-1:0] s_mask;
  int da [V];
  int db [V];
  int dc [V];

  logic [31:0] exp_q [$];
  int cnt_q [$];
  int m_acc [V];
  int m_cnt;
  bit m_open;

  always #5 clk = ~clk;

  vector_mac_pipe #(
    .E_WIDTH(8),
    .M_WIDTH(23),
    .VECTOR(V),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .first(first),
    .last(last),
    .lane_mask(lane_mask),
    .a_in(a_in),
    .b_in(b_in),
    .c_in(c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .out_count(out_count)
  );

  function automatic logic [31:0] to_fp(input int v);
    int m;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    r[31] = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0] = 23'((m << (23 - p)) & 32'h7FFFFF);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_accept();
    int r [V];
    int add;
    for (int i = 0; i < V; i++) begin
      if (!mode || first) add = dc[i];
      else add = m_open ? m_acc[i] : 0;
      r[i] = lane_mask[i] ? da[i] * db[i] + add : add;
    end
    if (!mode) begin
      for (int i = 0; i < V; i++) exp_q.push_back(to_fp(r[i]));
      cnt_q.push_back(1);
    end else begin
      m_cnt = (first || !m_open) ? 1 : m_cnt + 1;
      if (last) begin
        for (int i = 0; i < V; i++) exp_q.push_back(to_fp(r[i]));
        cnt_q.push_back(m_cnt);
        m_open = 0;
        m_cnt = 0;
        for (int i = 0; i < V; i++) m_acc[i] = 0;
      end else begin
        m_acc = r;
        m_open = 1;
      end
    end
  endtask

  task automatic step(input bit v, input bit ordy, output bit acc);
    @(posedge clk);
    #1;
    in_valid = v;
    out_ready = ordy;
    mode = s_mode;
    first = s_first;
    last = s_last;
    lane_mask = s_mask;
    for (int i = 0; i < V; i++) begin
      da[i] = sa[i];
      db[i] = sb[i];
      dc[i] = sc[i];
      a_in[i] = to_fp(sa[i]);
      b_in[i] = to_fp(sb[i]);
      c_in[i] = to_fp(sc[i]);
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) model_accept();
  endtask

  task automatic set_ops(input int a, input int b, input int c);
    for (int i = 0; i < V; i++) begin
      sa[i] = a;
      sb[i] = b;
      sc[i] = c;
    end
  endtask

  task automatic send(input bit md, input bit f, input bit l,
                      input logic [V-1:0] msk);
    bit acc;
    int n;
    s_mode = md;
    s_first = f;
    s_last = l;
    s_mask = msk;
    n = 0;
    acc = 0;
    while (!acc && n < 50) begin
      step(1'b1, 1'b1, acc);
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send: beat not accepted within %0d cycles", n);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (cnt_q.size() != 0 && n < 200) begin
      step(1'b0, 1'b1, acc);
      n++;
    end
    step(1'b0, 1'b1, acc);
    #2;
    check("drain_empty", 32'(cnt_q.size()), 32'd0);
  endtask

  task automatic expect_out(input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input int ecnt, input int elat, input string nm);
    bit acc;
    int n;
    logic [31:0] e [V];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    e[3] = e3;
    n = 0;
    while (!out_valid && n < 20) begin
      step(1'b0, 1'b1, acc);
      n++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: out_valid never rose", nm);
    end else begin
      for (int i = 0; i < V; i++)
        check($sformatf("%s_lane%0d", nm, i), out[i], e[i]);
      check({nm, "_count"}, 32'(out_count), 32'(ecnt));
      if (elat > 0) check({nm, "_latency"}, 32'(n), 32'(elat));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (cnt_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL model: unexpected output %h count %0d", out[0], out_count);
      end else begin
        for (int i = 0; i < V; i++)
          check($sformatf("model_lane%0d", i), out[i], exp_q[i]);
        check("model_count", 32'(out_count), 32'(cnt_q[0]));
        if (out_ready) begin
          repeat (V) void'(exp_q.pop_front());
          void'(cnt_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 1'b0;
    first = 1'b0;
    last = 1'b0;
    lane_mask = '0;
    s_mode = 0;
    s_first = 0;
    s_last = 0;
    s_mask = '0;
    m_open = 0;
    m_cnt = 0;
    set_ops(0, 0, 0);
    for (int i = 0; i < V; i++) begin
      m_acc[i] = 0;
      a_in[i] = '0;
      b_in[i] = '0;
      c_in[i] = '0;
    end
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out0", out[0], 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2*3+1 = 7 in every lane, one cycle after accept
    set_ops(2, 3, 1);
    send(1'b0, 1'b0, 1'b0, 4'b1111);
    expect_out(32'h40E00000, 32'h40E00000, 32'h40E00000, 32'h40E00000,
               1, 2, "fma");
    drain();

    send(1'b0, 1'b0, 1'b0, 4'b0101);
    expect_out(32'h40E00000, 32'h3F800000, 32'h40E00000, 32'h3F800000,
               1, 0, "mask");
    drain();

    // 4-beat dot product of ones
    set_ops(1, 1, 0);
    send(1'b1, 1'b1, 1'b0, 4'b1111);
    send(1'b1, 1'b0, 1'b0, 4'b1111);
    send(1'b1, 1'b0, 1'b0, 4'b1111);
    send(1'b1, 1'b0, 1'b1, 4'b1111);
    expect_out(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000,
               4, 0, "acc4");
    drain();
    set_ops(1, 1, 5);
    send(1'b1, 1'b0, 1'b1, 4'b1111);
    expect_out(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
               1, 0, "acc_cleared");
    drain();

    // 8-beat stream with out_ready low on cycles 3..5
    sent = 0;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < V; i++) begin
        sa[i] = int'($urandom_range(16, 0)) - 8;
        sb[i] = int'($urandom_range(16, 0)) - 8;
        sc[i] = int'($urandom_range(128, 0)) - 64;
      end
      s_mode = 0;
      s_mask = 4'($urandom);
      step(sent < 8, !(k >= 3 && k <= 5), acc);
      if (k == 4) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (acc) sent++;
    end
    check("stall_sent", 32'(sent), 32'd8);
    drain();

    // reset in the middle of a sequence
    set_ops(1, 1, 0);
    send(1'b1, 1'b1, 1'b0, 4'b1111);
    send(1'b1, 1'b0, 1'b0, 4'b1111);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    cnt_q.delete();
    m_open = 0;
    m_cnt = 0;
    for (int i = 0; i < V; i++) m_acc[i] = 0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_out3", out[3], 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1'b1, 1'b1, 1'b0, 4'b1111);
    send(1'b1, 1'b0, 1'b1, 4'b1111);
    expect_out(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
               2, 0, "post_rst");
    drain();

    // restart with first mid-sequence: only 2*2+4 then +1 = 9 emitted
    set_ops(1, 1, 0);
    send(1'b1, 1'b1, 1'b0, 4'b1111);
    send(1'b1, 1'b0, 1'b0, 4'b1111);
    set_ops(2, 2, 4);
    send(1'b1, 1'b1, 1'b0, 4'b1111);
    set_ops(1, 1, 0);
    send(1'b1, 1'b0, 1'b1, 4'b1111);
    expect_out(32'h41100000, 32'h41100000, 32'h41100000, 32'h41100000,
               2, 0, "restart");
    drain();
    set_ops(2, 3, 1);
    send(1'b1, 1'b1, 1'b1, 4'b1111);
    expect_out(32'h40E00000, 32'h40E00000, 32'h40E00000, 32'h40E00000,
               1, 0, "single");
    drain();

    // random traffic with back-pressure and interleaved modes
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < V; i++) begin
        sa[i] = int'($urandom_range(16, 0)) - 8;
        sb[i] = int'($urandom_range(16, 0)) - 8;
        sc[i] = int'($urandom_range(128, 0)) - 64;
      end
      s_mode = 1'($urandom_range(1, 0));
      s_first = ($urandom_range(3, 0) == 0);
      s_last = ($urandom_range(3, 0) == 0);
      s_mask = 4'($urandom);
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
